// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
//   state_t              : FSM state encoding (2 bits)
//   DEFAULT_RESET_VECTOR : PC value loaded on reset
//   DEFAULT_EXC_VECTOR   : redirect target on exception or misaligned target
//   PC_INCR              : sequential PC step
package fetch_sequencer_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam logic [XLEN-1:0] DEFAULT_EXC_VECTOR   = 32'h0000_0180;
   localparam logic [XLEN-1:0] PC_INCR              = 32'd4;

endpackage

// File: rtl/fetch_sequencer_pc.sv
// Program counter register with load enable.
//   clk, reset : clock, synchronous active-high reset (loads RESET_VALUE)
//   enable     : load data_in on the next edge
//   data_in    : next PC value
//   data_out   : current PC value
module pc #(
   parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] data_in,
   output logic [31:0] data_out
);

   always_ff @(posedge clk) begin
      if (reset)       data_out <= RESET_VALUE;
      else if (enable) data_out <= data_in;
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: requests words from instruction memory,
// issues them downstream, and handles redirects (exception > jump > branch).
//   clk, reset                 : clock, synchronous active-high reset
//   stall                      : downstream hold, blocks sequential PC advance
//   exception, jump, branch_taken, jump_target, branch_target : redirects
//   imem_req/addr/ack/rdata    : instruction-memory handshake
//   instr_out/valid/ready      : instruction issue handshake
//   pc_out                     : address of instruction in flight or held
//   addr_err                   : one-cycle pulse on misaligned redirect target
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        exception,
   input  logic        jump,
   input  logic        branch_taken,
   input  logic [31:0] jump_target,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_out,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] pc_out,
   output logic        addr_err
);

   state_t            state, next_state;
   logic [XLEN-1:0]   pending, pending_next;
   logic [XLEN-1:0]   instr_next;
   logic              valid_next;
   logic              err_next;
   logic              pc_en;
   logic [XLEN-1:0]   pc_next;

   logic              redirect;
   logic              misaligned;
   logic [XLEN-1:0]   raw_target;
   logic [XLEN-1:0]   target;

   // Redirect arbitration; misaligned targets fall back to the exception vector
   always_comb begin
      redirect   = exception | jump | branch_taken;
      raw_target = exception ? EXC_VECTOR : (jump ? jump_target : branch_target);
      misaligned = redirect && (raw_target[1:0] != 2'b00);
      target     = misaligned ? EXC_VECTOR : raw_target;
   end

   pc #(.RESET_VALUE(RESET_VECTOR)) u_pc (
      .clk      (clk),
      .reset    (reset),
      .enable   (pc_en),
      .data_in  (pc_next),
      .data_out (pc_out)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state and datapath control
   always_comb begin
      next_state   = state;
      pc_en        = 1'b0;
      pc_next      = pc_out;
      pending_next = pending;
      instr_next   = instr_out;
      valid_next   = instr_valid;
      err_next     = 1'b0;
      unique case (state)
         IDLE: begin
            next_state = FETCH;
            valid_next = 1'b0;
            if (redirect) begin
               pc_en    = 1'b1;
               pc_next  = target;
               err_next = misaligned;
            end
         end
         FETCH: begin
            if (imem_ack) begin
               if (redirect) begin
                  // Returned word belongs to the abandoned path
                  pc_en    = 1'b1;
                  pc_next  = target;
                  err_next = misaligned;
               end else begin
                  instr_next = imem_rdata;
                  valid_next = 1'b1;
                  next_state = ISSUE;
               end
            end else if (redirect) begin
               // Request already outstanding: keep it and drain its response
               pending_next = target;
               err_next     = misaligned;
               next_state   = DRAIN;
            end
         end
         ISSUE: begin
            if (redirect) begin
               pc_en      = 1'b1;
               pc_next    = target;
               err_next   = misaligned;
               valid_next = 1'b0;
               next_state = FETCH;
            end else if (instr_ready && !stall) begin
               pc_en      = 1'b1;
               pc_next    = pc_out + PC_INCR;
               valid_next = 1'b0;
               next_state = FETCH;
            end
         end
         DRAIN: begin
            valid_next = 1'b0;
            if (redirect) begin
               pending_next = target;
               err_next     = misaligned;
            end
            if (imem_ack) begin
               // Latest redirect wins, including one arriving with the ack
               pc_en      = 1'b1;
               pc_next    = redirect ? target : pending;
               next_state = FETCH;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Output and holding registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pending     <= '0;
         instr_out   <= '0;
         instr_valid <= 1'b0;
         addr_err    <= 1'b0;
         imem_req    <= 1'b0;
      end else begin
         pending     <= pending_next;
         instr_out   <= instr_next;
         instr_valid <= valid_next;
         addr_err    <= err_next;
         imem_req    <= (next_state == FETCH) || (next_state == DRAIN);
      end
   end

   // Address held in pc_out until the request completes
   assign imem_addr = pc_out;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: cycle table plus a delayed-ack sequence.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset, stall, exception, jump, branch_taken;
   logic [31:0] jump_target, branch_target;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] instr_out;
   logic        instr_valid, instr_ready;
   logic [31:0] pc_out;
   logic        addr_err;

   always #5 clk = ~clk;

   fetch_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .exception     (exception),
      .jump          (jump),
      .branch_taken  (branch_taken),
      .jump_target   (jump_target),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr_out     (instr_out),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .pc_out        (pc_out),
      .addr_err      (addr_err)
   );

   typedef struct {
      logic        rst, ack;
      logic [31:0] rdata;
      logic        ready, stl, exc, jmp;
      logic [31:0] jt;
      logic        br;
      logic [31:0] bt;
      logic        e_req;
      logic [31:0] e_pc;
      logic        e_valid;
      logic [31:0] e_instr;
      logic        e_err;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] sb_q[$];
   int          checks = 0;
   int          errors = 0;
   logic        prev_dut_valid = 1'b0;
   logic        prev_e_valid = 1'b0;

   function automatic vec_t v(logic rst, logic ack, logic [31:0] rdata, logic ready,
                              logic stl, logic exc, logic jmp, logic [31:0] jt,
                              logic br, logic [31:0] bt, logic e_req, logic [31:0] e_pc,
                              logic e_valid, logic [31:0] e_instr, logic e_err);
      vec_t r;
      r.rst = rst; r.ack = ack; r.rdata = rdata; r.ready = ready; r.stl = stl;
      r.exc = exc; r.jmp = jmp; r.jt = jt; r.br = br; r.bt = bt;
      r.e_req = e_req; r.e_pc = e_pc; r.e_valid = e_valid; r.e_instr = e_instr;
      r.e_err = e_err;
      return r;
   endfunction

   task automatic chk(string name, int row, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s row=%0d got=%h exp=%h", name, row, got, exp);
      end
   endtask

   // Scoreboard pop on each rising instr_valid
   task automatic sb_monitor(int row);
      if (instr_valid && !prev_dut_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected row=%0d got=%h exp=none", row, instr_out);
         end else begin
            chk("sb_instr", row, instr_out, sb_q.pop_front());
         end
      end
      prev_dut_valid = instr_valid;
   endtask

   task automatic drive_idle();
      reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0; stall = 1'b0;
      exception = 1'b0; jump = 1'b0; jump_target = '0; branch_taken = 1'b0;
      branch_target = '0;
   endtask

   initial begin
      drive_idle();
      //        rst ack rdata         rdy stl exc jmp jt            br bt             req pc            val instr         err
      vecs.push_back(v(1,0,32'h0,        0,0,0,0,32'h0,        0,32'h0,   0,32'h0,        0,32'h0,        0));
      vecs.push_back(v(0,0,32'h0,        0,0,0,0,32'h0,        0,32'h0,   1,32'h0,        0,32'h0,        0));
      vecs.push_back(v(0,1,32'h24080005, 1,0,0,0,32'h0,        0,32'h0,   0,32'h0,        1,32'h24080005, 0));
      vecs.push_back(v(0,0,32'h0,        1,0,0,0,32'h0,        0,32'h0,   1,32'h4,        0,32'h24080005, 0));
      vecs.push_back(v(0,1,32'h11111111, 0,0,0,0,32'h0,        0,32'h0,   0,32'h4,        1,32'h11111111, 0));
      vecs.push_back(v(0,0,32'h0,        1,1,0,0,32'h0,        0,32'h0,   0,32'h4,        1,32'h11111111, 0));
      vecs.push_back(v(0,0,32'h0,        1,1,0,0,32'h0,        0,32'h0,   0,32'h4,        1,32'h11111111, 0));
      vecs.push_back(v(0,0,32'h0,        1,1,0,0,32'h0,        0,32'h0,   0,32'h4,        1,32'h11111111, 0));
      vecs.push_back(v(0,0,32'h0,        1,0,0,0,32'h0,        0,32'h0,   1,32'h8,        0,32'h11111111, 0));
      vecs.push_back(v(0,1,32'h22222222, 0,0,0,0,32'h0,        0,32'h0,   0,32'h8,        1,32'h22222222, 0));
      vecs.push_back(v(0,0,32'h0,        0,0,0,1,32'h200,      1,32'h100, 1,32'h200,      0,32'h22222222, 0));
      vecs.push_back(v(0,0,32'h0,        0,0,0,0,32'h0,        1,32'h40,  1,32'h200,      0,32'h22222222, 0));
      vecs.push_back(v(0,0,32'h0,        0,0,0,0,32'h0,        0,32'h0,   1,32'h200,      0,32'h22222222, 0));
      vecs.push_back(v(0,1,32'hDEADBEEF, 0,0,0,0,32'h0,        0,32'h0,   1,32'h40,       0,32'h22222222, 0));
      vecs.push_back(v(0,0,32'h0,        0,0,0,0,32'h0,        0,32'h0,   1,32'h40,       0,32'h22222222, 0));
      vecs.push_back(v(0,1,32'h33333333, 0,0,0,0,32'h0,        0,32'h0,   0,32'h40,       1,32'h33333333, 0));
      vecs.push_back(v(0,0,32'h0,        0,0,0,1,32'h102,      0,32'h0,   1,32'h180,      0,32'h33333333, 1));
      vecs.push_back(v(0,0,32'h0,        0,0,0,0,32'h0,        0,32'h0,   1,32'h180,      0,32'h33333333, 0));
      vecs.push_back(v(0,1,32'h66666666, 0,0,0,1,32'hFFFFFFFC, 0,32'h0,   1,32'hFFFFFFFC, 0,32'h33333333, 0));
      vecs.push_back(v(0,1,32'h44444444, 0,0,0,0,32'h0,        0,32'h0,   0,32'hFFFFFFFC, 1,32'h44444444, 0));
      vecs.push_back(v(0,0,32'h0,        1,0,0,0,32'h0,        0,32'h0,   1,32'h0,        0,32'h44444444, 0));
      vecs.push_back(v(0,0,32'h0,        0,0,1,0,32'h0,        0,32'h0,   1,32'h0,        0,32'h44444444, 0));
      vecs.push_back(v(0,0,32'h0,        0,0,0,1,32'h300,      0,32'h0,   1,32'h0,        0,32'h44444444, 0));
      vecs.push_back(v(0,1,32'h0BADF00D, 0,0,0,0,32'h0,        0,32'h0,   1,32'h300,      0,32'h44444444, 0));
      vecs.push_back(v(0,0,32'h0,        0,0,0,0,32'h0,        1,32'h41,  1,32'h300,      0,32'h44444444, 1));
      vecs.push_back(v(0,1,32'h0BADF00D, 0,0,0,0,32'h0,        0,32'h0,   1,32'h180,      0,32'h44444444, 0));
      vecs.push_back(v(0,0,32'h0,        0,0,0,0,32'h0,        1,32'h50,  1,32'h180,      0,32'h44444444, 0));
      vecs.push_back(v(1,0,32'h0,        0,0,0,0,32'h0,        0,32'h0,   0,32'h0,        0,32'h0,        0));
      vecs.push_back(v(0,1,32'h77777777, 0,0,0,0,32'h0,        0,32'h0,   1,32'h0,        0,32'h0,        0));
      vecs.push_back(v(0,1,32'h55555555, 1,0,0,0,32'h0,        0,32'h0,   0,32'h0,        1,32'h55555555, 0));
      vecs.push_back(v(1,0,32'h0,        0,0,0,0,32'h0,        0,32'h0,   0,32'h0,        0,32'h0,        0));
      vecs.push_back(v(0,0,32'h0,        0,0,0,1,32'h80,       0,32'h0,   1,32'h80,       0,32'h0,        0));
      vecs.push_back(v(0,1,32'h88888888, 0,0,0,0,32'h0,        0,32'h0,   0,32'h80,       1,32'h88888888, 0));
      vecs.push_back(v(0,0,32'h0,        1,1,0,0,32'h0,        1,32'h400, 1,32'h400,      0,32'h88888888, 0));
      vecs.push_back(v(0,1,32'h99999999, 0,0,0,0,32'h0,        0,32'h0,   0,32'h400,      1,32'h99999999, 0));
      vecs.push_back(v(0,0,32'h0,        1,0,0,0,32'h0,        0,32'h0,   1,32'h404,      0,32'h99999999, 0));

      foreach (vecs[i]) begin
         @(negedge clk);
         reset = vecs[i].rst; imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
         instr_ready = vecs[i].ready; stall = vecs[i].stl; exception = vecs[i].exc;
         jump = vecs[i].jmp; jump_target = vecs[i].jt; branch_taken = vecs[i].br;
         branch_target = vecs[i].bt;
         if (vecs[i].ack && vecs[i].e_valid && !prev_e_valid) sb_q.push_back(vecs[i].rdata);
         prev_e_valid = vecs[i].e_valid;
         @(posedge clk);
         #1;
         chk("imem_req",    i, 32'(imem_req),    32'(vecs[i].e_req));
         chk("imem_addr",   i, imem_addr,        vecs[i].e_pc);
         chk("pc_out",      i, pc_out,           vecs[i].e_pc);
         chk("instr_valid", i, 32'(instr_valid), 32'(vecs[i].e_valid));
         chk("instr_out",   i, instr_out,        vecs[i].e_instr);
         chk("addr_err",    i, 32'(addr_err),    32'(vecs[i].e_err));
         if (vecs[i].rst) prev_dut_valid = 1'b0;
         sb_monitor(i);
      end

      // Long ack latency: request and address must stay stable until ack
      @(negedge clk);
      drive_idle();
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         chk("hold_req",   100 + k, 32'(imem_req),    32'h1);
         chk("hold_addr",  100 + k, imem_addr,        32'h404);
         chk("hold_valid", 100 + k, 32'(instr_valid), 32'h0);
      end
      imem_ack   = 1'b1;
      imem_rdata = 32'hABCD0123;
      sb_q.push_back(32'hABCD0123);
      begin
         int  cyc;
         logic seen;
         seen = 1'b0;
         cyc  = 0;
         while (!seen && cyc < 10) begin
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            cyc++;
            if (instr_valid) seen = 1'b1;
         end
         checks++;
         if (!seen) begin
            errors++;
            $display("FAIL valid_timeout got=%0d cycles exp=valid within 10", cyc);
         end
         chk("ack_latency", 200, 32'(cyc), 32'd1);
         sb_monitor(200);
         chk("late_pc", 200, pc_out, 32'h404);
      end

      chk("sb_empty", 300, 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
